// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_pkg
// Purpose  : Shared op encodings, timing defaults and FSM state type for the
//            VRAM burst engine and its cycle timer.
// Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam logic [1:0] VRAM_OP_READ    = 2'b00;
    localparam logic [1:0] VRAM_OP_WRITE_A = 2'b01;
    localparam logic [1:0] VRAM_OP_WRITE_B = 2'b10;
    localparam logic [1:0] VRAM_OP_WRITE   = 2'b11;

    localparam int DURATION_BITS = 6;

    // Power-on defaults for a conservative 64-clock bus cycle.
    localparam int DEFAULT_ASSERT_DELAY  = 15;
    localparam int DEFAULT_SAMPLE_DELAY  = 31;
    localparam int DEFAULT_RELEASE_DELAY = 47;
    localparam int DEFAULT_DURATION      = 63;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_WDATA = 3'd2,
        ST_CYCLE      = 3'd3,
        ST_PUSH       = 3'd4,
        ST_NEXT       = 3'd5,
        ST_FINISH     = 3'd6
    } vram_state_t;

    function automatic logic is_write_op(input logic [1:0] op);
        return op != VRAM_OP_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : vram_cycle_timer
// Purpose  : Times one VRAM bus cycle: strobe window, sample point and end.
// Revision : 1.0 - initial release
// ============================================================================
module vram_cycle_timer #(
    parameter int DURATION_BITS = vram_pkg::DURATION_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [DURATION_BITS-1:0] assert_delay,
    input  logic [DURATION_BITS-1:0] sample_delay,
    input  logic [DURATION_BITS-1:0] release_delay,
    input  logic [DURATION_BITS-1:0] duration,
    output logic                     strobe_active,
    output logic                     sample_pulse,
    output logic                     cycle_done
);

    logic [DURATION_BITS-1:0] r_cnt;

    // Counter sits at zero whenever go is low so each cycle starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!go || cycle_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DURATION_BITS'(1);
        end
    end

    assign strobe_active = go && (r_cnt >= assert_delay) && (r_cnt < release_delay);
    assign sample_pulse  = go && (r_cnt == sample_delay);
    assign cycle_done    = go && (r_cnt == duration);

endmodule
`default_nettype wire

// File: rtl/vram_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : vram_burst_engine
// Purpose  : Runs N back-to-back VRAM read/write bus cycles from one start
//            command. Optional macro VRAM_BURST_ADDR_STEP_EN adds addr_step_i.
// Revision : 1.0 - initial release
// ============================================================================
module vram_burst_engine #(
    parameter int DURATION_BITS = vram_pkg::DURATION_BITS,
    parameter int COUNT_BITS    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [1:0]               op_i,
    input  logic [14:0]              addr_i,
    input  logic [COUNT_BITS-1:0]    count_i,
    input  logic [DURATION_BITS-1:0] assert_delay_i,
    input  logic [DURATION_BITS-1:0] sample_delay_i,
    input  logic [DURATION_BITS-1:0] release_delay_i,
    input  logic [DURATION_BITS-1:0] duration_i,
`ifdef VRAM_BURST_ADDR_STEP_EN
    input  logic [7:0]               addr_step_i,
`endif
    input  logic                     abort_i,
    input  logic [15:0]              wdata_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    output logic [15:0]              rdata_o,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_timing_o,
    output logic                     vrd_n_o,
    output logic                     vawr_n_o,
    output logic                     vbwr_n_o,
    output logic                     va14_o,
    output logic [13:0]              vaa_o,
    output logic [13:0]              vab_o,
    output logic                     lvl_vd_dir_o,
    output logic                     vd_tristate_o,
    input  logic [7:0]               vda_i,
    input  logic [7:0]               vdb_i,
    output logic [7:0]               vda_o,
    output logic [7:0]               vdb_o
);

    import vram_pkg::*;

    vram_state_t               r_state;
    vram_state_t               w_next_state;
    logic [1:0]                r_op;
    logic [14:0]               r_addr;
    logic [COUNT_BITS-1:0]     r_remaining;
    logic [DURATION_BITS-1:0]  r_assert;
    logic [DURATION_BITS-1:0]  r_sample;
    logic [DURATION_BITS-1:0]  r_release;
    logic [DURATION_BITS-1:0]  r_duration;
    logic [15:0]               r_wdata;
    logic [15:0]               r_rdata;
    logic                      r_abort_seen;
    logic                      r_error;
    logic                      r_err_done;
    logic [14:0]               w_step;

    logic w_timing_legal;
    logic w_start_accept;
    logic w_is_write;
    logic w_in_cycle;
    logic w_strobe_active;
    logic w_sample_pulse;
    logic w_cycle_done;
    logic w_last;
    logic w_drive_data;

`ifdef VRAM_BURST_ADDR_STEP_EN
    logic [7:0] r_step;
    assign w_step = {7'd0, r_step};
`else
    assign w_step = 15'd1;
`endif

    assign w_timing_legal = (assert_delay_i < sample_delay_i)
                         && (sample_delay_i < release_delay_i)
                         && (release_delay_i <= duration_i);
    assign w_start_accept = (r_state == ST_IDLE) && start_i;
    assign w_is_write     = is_write_op(r_op);
    assign w_in_cycle     = (r_state == ST_CYCLE);
    assign w_last         = (r_remaining == COUNT_BITS'(1)) || r_abort_seen || abort_i;

    vram_cycle_timer #(
        .DURATION_BITS (DURATION_BITS)
    ) u_timer (
        .clk           (clock),
        .rst           (reset),
        .go            (w_in_cycle),
        .assert_delay  (r_assert),
        .sample_delay  (r_sample),
        .release_delay (r_release),
        .duration      (r_duration),
        .strobe_active (w_strobe_active),
        .sample_pulse  (w_sample_pulse),
        .cycle_done    (w_cycle_done)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i && w_timing_legal) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next_state = w_is_write ? ST_WAIT_WDATA : ST_CYCLE;
            end
            ST_WAIT_WDATA: begin
                if (wvalid_i) begin
                    w_next_state = ST_CYCLE;
                end
            end
            ST_CYCLE: begin
                if (w_cycle_done) begin
                    w_next_state = w_is_write ? ST_NEXT : ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (rready_i) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_last) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = w_is_write ? ST_WAIT_WDATA : ST_CYCLE;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= VRAM_OP_READ;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_assert     <= '0;
            r_sample     <= '0;
            r_release    <= '0;
            r_duration   <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_abort_seen <= 1'b0;
            r_error      <= 1'b0;
            r_err_done   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_err_done <= 1'b0;

            // Command fields are captured with the accepted start so they
            // only need to be valid alongside start_i.
            if (w_start_accept) begin
                if (w_timing_legal) begin
                    r_op        <= op_i;
                    r_addr      <= addr_i;
                    r_remaining <= count_i;
                    r_assert    <= assert_delay_i;
                    r_sample    <= sample_delay_i;
                    r_release   <= release_delay_i;
                    r_duration  <= duration_i;
                end else begin
                    r_error    <= 1'b1;
                    r_err_done <= 1'b1;
                end
            end

            if ((r_state == ST_WAIT_WDATA) && wvalid_i) begin
                r_wdata <= wdata_i;
            end

            if (w_sample_pulse && !w_is_write) begin
                r_rdata <= {vdb_i, vda_i};
            end

            if (r_state == ST_NEXT) begin
                r_addr      <= r_addr + w_step;
                r_remaining <= r_remaining - COUNT_BITS'(1);
            end

            if ((r_state == ST_IDLE) || (r_state == ST_NEXT)) begin
                r_abort_seen <= 1'b0;
            end else if (abort_i) begin
                r_abort_seen <= 1'b1;
            end
        end
    end

`ifdef VRAM_BURST_ADDR_STEP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step <= 8'd0;
        end else if (w_start_accept && w_timing_legal) begin
            r_step <= addr_step_i;
        end
    end
`endif

    assign w_drive_data   = w_in_cycle && w_is_write;

    assign wready_o       = (r_state == ST_WAIT_WDATA) && wvalid_i;
    assign rvalid_o       = (r_state == ST_PUSH);
    assign rdata_o        = r_rdata;
    assign busy_o         = (r_state != ST_IDLE);
    assign done_o         = (r_state == ST_FINISH) || r_err_done;
    assign error_timing_o = r_error;

    // Read and write strobes are mutually exclusive by op decode.
    assign vrd_n_o        = !(w_strobe_active && !w_is_write);
    assign vawr_n_o       = !(w_strobe_active && w_is_write && r_op[0]);
    assign vbwr_n_o       = !(w_strobe_active && w_is_write && r_op[1]);

    assign va14_o         = busy_o ? r_addr[14]   : 1'b0;
    assign vaa_o          = busy_o ? r_addr[13:0] : 14'd0;
    assign vab_o          = busy_o ? r_addr[13:0] : 14'd0;

    assign lvl_vd_dir_o   = w_drive_data;
    assign vd_tristate_o  = !w_drive_data;
    assign vda_o          = w_drive_data ? r_wdata[7:0]  : 8'd0;
    assign vdb_o          = w_drive_data ? r_wdata[15:8] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_vram_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_burst_engine
// Purpose  : Scoreboard bench for vram_burst_engine with a modelled VRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_burst_engine;
    import vram_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [14:0] addr_i;
    logic [7:0]  count_i;
    logic [5:0]  assert_delay_i, sample_delay_i, release_delay_i, duration_i;
    logic [7:0]  addr_step;
    logic        abort_i;
    logic [15:0] wdata_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [15:0] rdata_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        busy_o, done_o, error_timing_o;
    logic        vrd_n_o, vawr_n_o, vbwr_n_o;
    logic        va14_o;
    logic [13:0] vaa_o, vab_o;
    logic        lvl_vd_dir_o, vd_tristate_o;
    logic [7:0]  vda_i, vdb_i, vda_o, vdb_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] w_words[0:15];

    int          t_now;
    int          p_start[$];
    int          p_len[$];
    logic [14:0] p_addr[$];
    int          hs_r_time[$];
    int          done_cnt;
    int          lvl_clocks;
    bit          f_both, f_rd_in_wr, f_prehs, f_lvl, f_tri, f_stable;

    always #5 clock = ~clock;

    function automatic logic [15:0] vram_word(input logic [14:0] a);
        return {a[14:7] ^ 8'hA5, a[7:0] ^ 8'h3C};
    endfunction

    assign {vdb_i, vda_i} = vram_word({va14_o, vaa_o});

    vram_burst_engine #(.DURATION_BITS(6), .COUNT_BITS(8)) dut (
        .clock(clock), .reset(reset), .start_i(start_i), .op_i(op_i), .addr_i(addr_i),
        .count_i(count_i), .assert_delay_i(assert_delay_i), .sample_delay_i(sample_delay_i),
        .release_delay_i(release_delay_i), .duration_i(duration_i),
`ifdef VRAM_BURST_ADDR_STEP_EN
        .addr_step_i(addr_step),
`endif
        .abort_i(abort_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i), .busy_o(busy_o),
        .done_o(done_o), .error_timing_o(error_timing_o), .vrd_n_o(vrd_n_o),
        .vawr_n_o(vawr_n_o), .vbwr_n_o(vbwr_n_o), .va14_o(va14_o), .vaa_o(vaa_o),
        .vab_o(vab_o), .lvl_vd_dir_o(lvl_vd_dir_o), .vd_tristate_o(vd_tristate_o),
        .vda_i(vda_i), .vdb_i(vdb_i), .vda_o(vda_o), .vdb_o(vdb_o)
    );

    task automatic start_burst(input logic [1:0] op, input logic [14:0] addr, input logic [7:0] cnt,
                               input logic [5:0] a, input logic [5:0] s, input logic [5:0] r,
                               input logic [5:0] d);
        op_i = op; addr_i = addr; count_i = cnt;
        assert_delay_i = a; sample_delay_i = s; release_delay_i = r; duration_i = d;
        start_i = 1'b1;
    endtask

    task automatic push_reads(input logic [14:0] addr, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(vram_word(15'(addr + 15'(k))));
    endtask

    // Steps one burst to completion, recording strobe pulses and checking
    // read/write words against the scoreboard as the DUT produces them.
    task automatic run_burst(input int max_clk, input bit is_wr, input int rr_low,
                             input int wgap, input int abort_pulse);
        bit          prev_low = 1'b0;
        bit          cur_low;
        bit          seen_done = 1'b0;
        bit          prev_stall = 1'b0;
        logic [15:0] prev_rdata = '0;
        logic [15:0] exp;
        int          hold = 0;
        int          gap = wgap;
        int          hs_w = 0;
        int          low_len = 0;
        p_start.delete(); p_len.delete(); p_addr.delete(); hs_r_time.delete();
        done_cnt = 0; lvl_clocks = 0; t_now = 0;
        f_both = 0; f_rd_in_wr = 0; f_prehs = 0; f_lvl = 0; f_tri = 0; f_stable = 0;
        for (int i = 0; i < max_clk && !seen_done; i++) begin
            @(posedge clock); #1;
            t_now++;
            start_i = 1'b0;
            abort_i = 1'b0;
            cur_low = !(vrd_n_o && vawr_n_o && vbwr_n_o);
            if (cur_low && !prev_low) begin
                p_start.push_back(t_now);
                p_addr.push_back({va14_o, vaa_o});
                low_len = 0;
                if (is_wr && hs_w < p_start.size()) f_prehs = 1;
                if (abort_pulse != 0 && p_start.size() == abort_pulse) abort_i = 1'b1;
            end
            if (cur_low) begin
                low_len++;
                if (is_wr) begin
                    if (vawr_n_o !== vbwr_n_o) f_both = 1;
                    if (vrd_n_o === 1'b0) f_rd_in_wr = 1;
                    if (lvl_vd_dir_o !== 1'b1) f_lvl = 1;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL write_data: bus %h driven with no expected word", {vdb_o, vda_o});
                    end else if ({vdb_o, vda_o} !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL write_data: got %h expected %h", {vdb_o, vda_o}, exp_q[0]);
                    end
                end
            end
            if (!cur_low && prev_low) begin
                p_len.push_back(low_len);
                if (is_wr && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_low = cur_low;
            if (done_o) begin done_cnt++; seen_done = 1'b1; end
            if (lvl_vd_dir_o) lvl_clocks++;
            if (vd_tristate_o !== !lvl_vd_dir_o) f_tri = 1;
            if (prev_stall && (rvalid_o !== 1'b1 || rdata_o !== prev_rdata)) f_stable = 1;
            if (rvalid_o && hold < rr_low) begin rready_i = 1'b0; hold++; end
            else rready_i = 1'b1;
            if (is_wr) begin
                if (gap > 0) begin wvalid_i = 1'b0; gap--; end
                else begin wvalid_i = 1'b1; wdata_i = w_words[hs_w]; end
            end
            #1;
            if (wvalid_i && wready_o) begin
                exp_q.push_back(wdata_i);
                hs_w++;
                gap = wgap;
            end
            if (lvl_vd_dir_o && wready_o) f_lvl = 1;
            if (rvalid_o && rready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_data: got %h with no expected word", rdata_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (rdata_o !== exp) begin
                        n_fail++;
                        $display("FAIL read_data: got %h expected %h", rdata_o, exp);
                    end
                end
                hs_r_time.push_back(t_now);
                hold = 0;
                prev_stall = 1'b0;
            end else begin
                prev_stall = rvalid_o;
                prev_rdata = rdata_o;
            end
        end
        wvalid_i = 1'b0; rready_i = 1'b1; abort_i = 1'b0; start_i = 1'b0;
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL burst_timeout: no done_o within %0d clocks", max_clk);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({busy_o, done_o, rvalid_o, wready_o, error_timing_o, lvl_vd_dir_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy_o, done_o, rvalid_o, wready_o, error_timing_o, lvl_vd_dir_o});
        end
        n_checks++;
        if ({vrd_n_o, vawr_n_o, vbwr_n_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 111", {vrd_n_o, vawr_n_o, vbwr_n_o});
        end
        n_checks++;
        if ({va14_o, vaa_o, vab_o, vda_o, vdb_o, rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: addr %h/%h data %h%h rdata %h expected all zero",
                     {va14_o, vaa_o}, vab_o, vdb_o, vda_o, rdata_o);
        end
        n_checks++;
        if (vd_tristate_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tristate: got %b expected 1", vd_tristate_o);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_read_burst;
        push_reads(15'h0100, 4);
        start_burst(VRAM_OP_READ, 15'h0100, 8'd4, 6'd2, 6'd4, 6'd6, 6'd8);
        run_burst(200, 1'b0, 0, 0, 0);
        n_checks++;
        if (p_start.size() != 4 || p_len.size() != 4) begin
            n_fail++;
            $display("FAIL read_pulse_count: got %0d expected 4", p_start.size());
        end else begin
            n_checks++;
            if (p_start[0] != 4) begin
                n_fail++;
                $display("FAIL read_latency: first strobe at clock %0d expected 4", p_start[0]);
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (p_len[k] != 4 || p_addr[k] != 15'(15'h0100 + k)) begin
                    n_fail++;
                    $display("FAIL read_pulse%0d: len %0d addr %h expected 4 and %h",
                             k, p_len[k], p_addr[k], 15'(15'h0100 + k));
                end
                if (k > 0) begin
                    n_checks++;
                    if (p_start[k] - p_start[k-1] != 11) begin
                        n_fail++;
                        $display("FAIL read_period%0d: got %0d expected 11",
                                 k, p_start[k] - p_start[k-1]);
                    end
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL read_done: done %0d left %0d expected 1 and 0", done_cnt, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_write_both;
        for (int k = 0; k < 16; k++) w_words[k] = 16'($urandom_range(0, 65535));
        start_burst(VRAM_OP_WRITE, 15'h0200, 8'd3, 6'd2, 6'd4, 6'd6, 6'd8);
        run_burst(400, 1'b1, 0, 5, 0);
        n_checks++;
        if (p_start.size() != 3 || p_len.size() != 3) begin
            n_fail++;
            $display("FAIL write_pulse_count: got %0d expected 3", p_start.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (p_len[k] != 4 || p_addr[k] != 15'(15'h0200 + k)) begin
                    n_fail++;
                    $display("FAIL write_pulse%0d: len %0d addr %h expected 4 and %h",
                             k, p_len[k], p_addr[k], 15'(15'h0200 + k));
                end
            end
        end
        n_checks++;
        if ({f_both, f_rd_in_wr, f_prehs, f_lvl, f_tri} !== 5'b0) begin
            n_fail++;
            $display("FAIL write_bus_rules: both/rd/prehs/lvl/tri flags %b expected 00000",
                     {f_both, f_rd_in_wr, f_prehs, f_lvl, f_tri});
        end
        n_checks++;
        if (lvl_clocks != 27) begin
            n_fail++;
            $display("FAIL write_dir_clocks: got %0d expected 27", lvl_clocks);
        end
        n_checks++;
        if (done_cnt != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_done: done %0d left %0d expected 1 and 0", done_cnt, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_pressure;
        push_reads(15'h0AA0, 2);
        start_burst(VRAM_OP_READ, 15'h0AA0, 8'd2, 6'd2, 6'd4, 6'd6, 6'd8);
        run_burst(300, 1'b0, 20, 0, 0);
        n_checks++;
        if (f_stable) begin
            n_fail++;
            $display("FAIL bp_stable: rvalid/rdata changed while stalled");
        end
        n_checks++;
        if (p_start.size() != 2 || hs_r_time.size() != 2) begin
            n_fail++;
            $display("FAIL bp_counts: pulses %0d handshakes %0d expected 2 and 2",
                     p_start.size(), hs_r_time.size());
        end else begin
            n_checks++;
            if (p_start[1] != hs_r_time[0] + 4) begin
                n_fail++;
                $display("FAIL bp_second_strobe: at clock %0d expected %0d",
                         p_start[1], hs_r_time[0] + 4);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap_length;
        push_reads(15'h7FFF, 256);
        start_burst(VRAM_OP_READ, 15'h7FFF, 8'd0, 6'd1, 6'd2, 6'd4, 6'd4);
        run_burst(2500, 1'b0, 0, 0, 0);
        n_checks++;
        if (p_start.size() != 256) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d cycles expected 256", p_start.size());
        end else begin
            n_checks++;
            if (p_addr[0] != 15'h7FFF || p_addr[1] != 15'h0000 || p_addr[255] != 15'h00FE) begin
                n_fail++;
                $display("FAIL wrap_addr: got %h %h %h expected 7fff 0000 00fe",
                         p_addr[0], p_addr[1], p_addr[255]);
            end
            n_checks++;
            if (p_len[0] != 3 || p_start[1] - p_start[0] != 7) begin
                n_fail++;
                $display("FAIL wrap_timing: len %0d period %0d expected 3 and 7",
                         p_len[0], p_start[1] - p_start[0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_reads: %0d words unread expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_errors_abort_idle;
        int d, s, b;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) start_burst(VRAM_OP_READ, 15'h0300, 8'd4, 6'd5, 6'd5, 6'd6, 6'd8);
            else           start_burst(VRAM_OP_WRITE, 15'h0300, 8'd4, 6'd2, 6'd4, 6'd9, 6'd8);
            d = 0; s = 0; b = 0;
            repeat (6) begin
                @(posedge clock); #1;
                start_i = 1'b0;
                if (done_o) d++;
                if (!(vrd_n_o && vawr_n_o && vbwr_n_o)) s++;
                if (busy_o) b++;
            end
            n_checks++;
            if (error_timing_o !== 1'b1 || d != 1 || s != 0 || b != 0) begin
                n_fail++;
                $display("FAIL timing_error%0d: err %b done %0d strobes %0d busy %0d expected 1 1 0 0",
                         pass, error_timing_o, d, s, b);
            end
        end
        abort_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        abort_i = 1'b0;
        push_reads(15'h0310, 2);
        start_burst(VRAM_OP_READ, 15'h0310, 8'd2, 6'd2, 6'd4, 6'd6, 6'd8);
        run_burst(200, 1'b0, 0, 0, 0);
        n_checks++;
        if (p_start.size() != 2) begin
            n_fail++;
            $display("FAIL abort_idle: got %0d cycles expected 2", p_start.size());
        end
        exp_q.delete();
    endtask

    task automatic test_abort;
        push_reads(15'h0600, 10);
        start_burst(VRAM_OP_READ, 15'h0600, 8'd10, 6'd2, 6'd4, 6'd6, 6'd8);
        run_burst(400, 1'b0, 0, 0, 2);
        n_checks++;
        if (p_start.size() != 2 || p_len.size() != 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_stop: pulses %0d done %0d expected 2 and 1", p_start.size(), done_cnt);
        end else begin
            n_checks++;
            if (p_len[1] != 4 || exp_q.size() != 8) begin
                n_fail++;
                $display("FAIL abort_cycle2: len %0d unread %0d expected 4 and 8", p_len[1], exp_q.size());
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_burst;
        bit found = 1'b0;
        start_burst(VRAM_OP_READ, 15'h0400, 8'd5, 6'd2, 6'd4, 6'd6, 6'd8);
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            start_i = 1'b0;
            if (vrd_n_o === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_wait: no strobe within 20 clocks");
        end
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if ({vrd_n_o, vawr_n_o, vbwr_n_o, busy_o, error_timing_o} !== 5'b11100) begin
            n_fail++;
            $display("FAIL rst_mid_strobe: strobes/busy/err %b expected 11100",
                     {vrd_n_o, vawr_n_o, vbwr_n_o, busy_o, error_timing_o});
        end
        reset = 1'b0;
        @(posedge clock); #1;
        start_burst(VRAM_OP_READ, 15'h0500, 8'd2, 6'd2, 6'd4, 6'd6, 6'd8);
        rready_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clock); #1;
            start_i = 1'b0;
            if (rvalid_o === 1'b1) found = 1'b1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (!found || rvalid_o !== 1'b0 || rdata_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_held_word: seen %b rvalid %b rdata %h expected 1 0 0000",
                     found, rvalid_o, rdata_o);
        end
        reset = 1'b0;
        rready_i = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; op_i = 2'b00; addr_i = '0; count_i = '0;
        assert_delay_i = 6'(DEFAULT_ASSERT_DELAY); sample_delay_i = 6'(DEFAULT_SAMPLE_DELAY);
        release_delay_i = 6'(DEFAULT_RELEASE_DELAY); duration_i = 6'(DEFAULT_DURATION);
        addr_step = 8'd1; abort_i = 1'b0; wdata_i = '0; wvalid_i = 1'b0; rready_i = 1'b1;
        test_reset;
        test_read_burst;
        test_write_both;
        test_back_pressure;
        test_wrap_length;
        test_errors_abort_idle;
        test_abort;
        test_reset_mid_burst;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_burst_engine.md
Name: vram_burst_engine

Overview:
- Sequences multi-cycle VRAM bursts autonomously: one start command runs N back-to-back read or write bus cycles with auto-incrementing address and programmable strobe timing.
- Sits between the host command decoder and the VRAM pins, replacing per-byte host cycling for bulk fills and dumps.
- Write data enters through a ready/valid stream; read data leaves through a ready/valid stream. Bus cycles stall, never drop, on back-pressure.

Parameters:
DURATION_BITS, 6, width of every timing field and of the in-cycle counter
COUNT_BITS, 8, width of the burst length; value 0 means 2^COUNT_BITS cycles

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high; returns block to IDLE
start_i  in  1  one-cycle pulse; accepted only in IDLE
op_i  in  2  00 read, 01 write A, 10 write B, 11 write both
addr_i  in  15  start address; bit 14 drives va14, bits 13:0 drive vaa/vab
count_i  in  COUNT_BITS  number of cycles in the burst
assert_delay_i, sample_delay_i, release_delay_i, duration_i  in  DURATION_BITS each  timing, sampled at start
abort_i  in  1  finish the current bus cycle, then stop
wdata_i  in  16  {vdb, vda} write data
wvalid_i  in  1  write data valid
wready_o  out  1  write word consumed this clock
rdata_o  out  16  {vdb, vda} sampled read data
rvalid_o  out  1  read word held
rready_i  in  1  downstream accepts rdata_o
busy_o  out  1  state != IDLE
done_o  out  1  one-clock pulse at burst end, normal or aborted
error_timing_o  out  1  sticky; cleared only by reset
vrd_n_o, vawr_n_o, vbwr_n_o  out  1 each  active-low strobes
va14_o  out  1  address bit 14
vaa_o, vab_o  out  14 each  address buses
lvl_vd_dir_o  out  1  1 = FPGA drives data
vd_tristate_o  out  1  always !lvl_vd_dir_o
vda_i, vdb_i  in  8 each  data from VRAM
vda_o, vdb_o  out  8 each  data to VRAM

Behaviour:
- Reset values:
  - busy_o, done_o, rvalid_o, wready_o, error_timing_o, lvl_vd_dir_o = 0.
  - All strobes = 1.
  - Addresses and data outputs = 0.
  - vd_tristate_o = 1.
- Reset mid-burst: strobes release on the next clock edge. Any held read word is discarded.
- Start validation:
  - start_i is legal only if assert < sample < release <= duration.
  - Otherwise set error_timing_o, pulse done_o, stay IDLE.
  - start_i outside IDLE is ignored.
- States: IDLE -> LOAD -> (write op: WAIT_WDATA) -> CYCLE -> (read op: PUSH) -> NEXT -> CYCLE or FINISH -> IDLE.
  - LOAD: latch op, address, count and timing.
  - WAIT_WDATA: wready_o = wvalid_i. On handshake, latch the word and enter CYCLE.
  - CYCLE: counter runs 0..duration. At assert_delay the op strobe goes low. At sample_delay a read op captures {vdb_i, vda_i}. At release_delay the strobe goes high. Leave at duration. Each phase lasts exactly (delay difference) clocks.
  - PUSH: rvalid_o = 1 with data stable until rready_i. Advance on handshake. The next bus cycle does not begin while a word is held.
  - NEXT: address = address + 1, wrapping 0x7FFF -> 0x0000 with va14 included. remaining = remaining - 1.
    - If remaining reaches 0, or abort_i has been seen since the last NEXT, go to FINISH.
    - Otherwise go to WAIT_WDATA (write op) or CYCLE (read op).
  - FINISH: done_o = 1 for one clock, then IDLE.
- Bus drive:
  - Address is driven only outside IDLE, otherwise 0.
  - lvl_vd_dir_o = 1 only in CYCLE for write ops. vda_o/vdb_o carry the latched word only then, otherwise 0.
  - vrd_n_o and a write strobe are never low together.
- Burst-level timing:
  - Read op with rready_i held high: per-cycle cost is (duration + 1) + 2 clocks.
  - Start-to-first-strobe latency is 2 + assert_delay clocks.
- abort_i asserted in IDLE has no effect.

Optional Feature:
- Macro VRAM_BURST_ADDR_STEP_EN.
- When defined: adds input addr_step_i (8 bits, latched in LOAD). NEXT adds addr_step_i, mod 2^15. Step 0 repeats the same address.
- When undefined: the port is absent and the step is fixed at 1.

Decomposition:
- Package vram_pkg holds:
  - op encoding constants VRAM_OP_READ/WRITE_A/WRITE_B/WRITE;
  - DURATION_BITS;
  - default timing values 15/31/47/63;
  - the state enum.
- One sub-module, vram_cycle_timer:
  - inputs: go, the four delays;
  - outputs: strobe_active, sample_pulse, cycle_done.
  - It is reusable by the existing byte-command controller.

Test Plan:
- Read burst: addr 0x0100, count 4, delays 2/4/6/8, rready_i = 1. Expect:
  - vrd_n_o low for 4 clocks per cycle;
  - vaa_o = 0x100..0x103;
  - 4 rdata_o words match the modelled VRAM;
  - done_o once;
  - 11 clocks per cycle.
- Write-both burst: count 3, wvalid_i gapped by 5 clocks. Expect:
  - no strobe before each handshake;
  - vda_o/vdb_o = latched words;
  - vawr_n_o and vbwr_n_o low together;
  - lvl_vd_dir_o = 1 only in CYCLE.
- Back-pressure: read count 2, rready_i held low 20 clocks. Expect:
  - rvalid_o and rdata_o stable;
  - no second vrd_n_o pulse until the handshake.
- Wrap and length: addr 0x7FFF, count 0. Expect 256 cycles, second address 0x0000, va14_o dropping to 0.
- Errors and abort: delays 5/5/6/8, then start. Expect error_timing_o = 1, done_o, no strobes.
- Abort and reset:
  - abort_i mid-cycle 2 of 10: cycle 2 completes, then done_o.
  - reset mid-strobe: all strobes high next clock.
